// File: rtl/rs_encode_pkg.sv
// Shared defaults for the line-based RS encoder family.
package rs_encode_pkg;
    localparam int RS_DATA_W   = 512;
    localparam int RS_PARITY_W = 256;
endpackage

// File: rtl/rs_encode_rr_pkg.sv
// Types and constants for the round-robin distributor/collector.
package rs_encode_rr_pkg;
    import rs_encode_pkg::*;

    localparam int META_DEPTH  = 2;
    localparam int RR_DATA_W   = RS_DATA_W;
    localparam int RR_PARITY_W = RS_PARITY_W;

    typedef enum logic {IN_IDLE, IN_DATA} in_state_e;
    typedef enum logic [1:0] {OUT_IDLE, OUT_DATA, OUT_PARITY} out_state_e;
endpackage

// File: rtl/rs_req_meta_fifo.sv
// Small synchronous FIFO carrying per-request block counts from input to output side.
module rs_req_meta_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_val_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             push_rdy_o,
    output logic             pop_val_o,
    output logic [WIDTH-1:0] pop_data_o,
    input  logic             pop_rdy_i
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push, pop;

    assign push_rdy_o = (count_q != (PTR_W+1)'(DEPTH));
    assign pop_val_o  = (count_q != '0);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign push       = push_val_i && push_rdy_o;
    assign pop        = pop_val_o && pop_rdy_i;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PTR_W+1)'(1);
            end
        end
    end
endmodule

// File: rtl/rs_encode_rr_dist_collect.sv
// Round-robin block distributor and in-order collector for a bank of RS encoder units;
// each block's data lines come back followed by that block's parity line.
module rs_encode_rr_dist_collect
    import rs_encode_rr_pkg::*;
#(
    parameter int DATA_W           = RR_DATA_W,
    parameter int PARITY_W         = RR_PARITY_W,
    parameter int NUM_RS_UNITS     = 3,
    parameter int NUM_LINES        = 4,
    parameter int NUM_REQ_BLOCKS_W = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             src_dist_req_val,
    input  logic [NUM_REQ_BLOCKS_W-1:0]      src_dist_req_num_blocks,
    output logic                             dist_src_req_rdy,
    input  logic                             src_dist_data_val,
    input  logic [DATA_W-1:0]                src_dist_data,
    output logic                             dist_src_data_rdy,
    output logic [NUM_RS_UNITS-1:0]          dist_unit_vals,
    output logic [DATA_W-1:0]                dist_unit_line,
    input  logic [NUM_RS_UNITS-1:0]          unit_dist_rdys,
    input  logic [NUM_RS_UNITS-1:0]          unit_coll_vals,
    input  logic [NUM_RS_UNITS*DATA_W-1:0]   unit_coll_lines,
    input  logic [NUM_RS_UNITS*PARITY_W-1:0] unit_coll_paritys,
    output logic [NUM_RS_UNITS-1:0]          coll_unit_rdys,
    output logic                             dist_dst_data_val,
    output logic [DATA_W-1:0]                dist_dst_data,
    output logic                             dist_dst_last,
    input  logic                             dst_dist_data_rdy
);
    localparam int UNIT_W = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1;
    localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int BLK_W  = NUM_REQ_BLOCKS_W;

    // Compare-based wrap so any unit count works; shared by both sides to keep block order aligned.
    function automatic logic [UNIT_W-1:0] unit_wrap(input logic [UNIT_W-1:0] ptr);
        return (ptr == UNIT_W'(NUM_RS_UNITS-1)) ? '0 : ptr + UNIT_W'(1);
    endfunction

    in_state_e          in_state_q, in_state_d;
    logic [BLK_W-1:0]   in_blocks_left_q, in_blocks_left_d;
    logic [LINE_W-1:0]  in_line_q, in_line_d;
    logic [UNIT_W-1:0]  in_unit_q, in_unit_d;
    out_state_e         out_state_q, out_state_d;
    logic [BLK_W-1:0]   out_blocks_left_q, out_blocks_left_d;
    logic [LINE_W-1:0]  out_line_q, out_line_d;
    logic [UNIT_W-1:0]  out_unit_q, out_unit_d;
    logic [PARITY_W-1:0] parity_q, parity_d;

    logic               meta_push_val, meta_push_rdy, meta_pop_val, meta_pop_rdy;
    logic [BLK_W-1:0]   meta_pop_data;

    logic                    req_rdy_c, data_rdy_c, dst_val_c, dst_last_c;
    logic [NUM_RS_UNITS-1:0] unit_vals_c, coll_rdys_c;
    logic [DATA_W-1:0]       dst_data_c;

    logic [DATA_W-1:0]   coll_line_arr [NUM_RS_UNITS];
    logic [PARITY_W-1:0] coll_par_arr  [NUM_RS_UNITS];

    for (genvar gi = 0; gi < NUM_RS_UNITS; gi++) begin : g_unit_slice
        assign coll_line_arr[gi] = unit_coll_lines[gi*DATA_W +: DATA_W];
        assign coll_par_arr[gi]  = unit_coll_paritys[gi*PARITY_W +: PARITY_W];
    end

    rs_req_meta_fifo #(.WIDTH(BLK_W), .DEPTH(META_DEPTH)) u_meta_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_val_i  (meta_push_val),
        .push_data_i (src_dist_req_num_blocks),
        .push_rdy_o  (meta_push_rdy),
        .pop_val_o   (meta_pop_val),
        .pop_data_o  (meta_pop_data),
        .pop_rdy_i   (meta_pop_rdy)
    );

    always_comb begin
        in_state_d       = in_state_q;
        in_blocks_left_d = in_blocks_left_q;
        in_line_d        = in_line_q;
        in_unit_d        = in_unit_q;
        req_rdy_c        = 1'b0;
        data_rdy_c       = 1'b0;
        unit_vals_c      = '0;
        meta_push_val    = 1'b0;
        case (in_state_q)
            IN_IDLE: begin
                req_rdy_c     = meta_push_rdy;
                meta_push_val = src_dist_req_val;
                if (src_dist_req_val && meta_push_rdy) begin
                    in_blocks_left_d = src_dist_req_num_blocks;
                    in_line_d        = '0;
                    in_state_d       = IN_DATA;
                end
            end
            IN_DATA: begin
                unit_vals_c[in_unit_q] = src_dist_data_val;
                data_rdy_c             = unit_dist_rdys[in_unit_q];
                if (src_dist_data_val && unit_dist_rdys[in_unit_q]) begin
                    if (in_line_q == LINE_W'(NUM_LINES-1)) begin
                        in_line_d        = '0;
                        in_unit_d        = unit_wrap(in_unit_q);
                        in_blocks_left_d = in_blocks_left_q - BLK_W'(1);
                        if (in_blocks_left_q == BLK_W'(1)) begin
                            in_state_d = IN_IDLE;
                        end
                    end else begin
                        in_line_d = in_line_q + LINE_W'(1);
                    end
                end
            end
            default: in_state_d = IN_IDLE;
        endcase
    end

    always_comb begin
        out_state_d       = out_state_q;
        out_blocks_left_d = out_blocks_left_q;
        out_line_d        = out_line_q;
        out_unit_d        = out_unit_q;
        parity_d          = parity_q;
        meta_pop_rdy      = 1'b0;
        dst_val_c         = 1'b0;
        dst_data_c        = '0;
        dst_last_c        = 1'b0;
        coll_rdys_c       = '0;
        case (out_state_q)
            OUT_IDLE: begin
                meta_pop_rdy = 1'b1;
                if (meta_pop_val) begin
                    out_blocks_left_d = meta_pop_data;
                    out_line_d        = '0;
                    out_state_d       = OUT_DATA;
                end
            end
            OUT_DATA: begin
                dst_val_c               = unit_coll_vals[out_unit_q];
                dst_data_c              = coll_line_arr[out_unit_q];
                coll_rdys_c[out_unit_q] = dst_dist_data_rdy;
                if (unit_coll_vals[out_unit_q] && dst_dist_data_rdy) begin
                    if (out_line_q == LINE_W'(NUM_LINES-1)) begin
                        parity_d    = coll_par_arr[out_unit_q];
                        out_unit_d  = unit_wrap(out_unit_q);
                        out_line_d  = '0;
                        out_state_d = OUT_PARITY;
                    end else begin
                        out_line_d = out_line_q + LINE_W'(1);
                    end
                end
            end
            OUT_PARITY: begin
                // Shift rather than concatenate so PARITY_W == DATA_W needs no zero-width field.
                dst_val_c  = 1'b1;
                dst_data_c = DATA_W'(parity_q) << (DATA_W - PARITY_W);
                dst_last_c = (out_blocks_left_q == BLK_W'(1));
                if (dst_dist_data_rdy) begin
                    out_blocks_left_d = out_blocks_left_q - BLK_W'(1);
                    out_state_d       = (out_blocks_left_q == BLK_W'(1)) ? OUT_IDLE : OUT_DATA;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_q        <= IN_IDLE;
            in_blocks_left_q  <= '0;
            in_line_q         <= '0;
            in_unit_q         <= '0;
            out_state_q       <= OUT_IDLE;
            out_blocks_left_q <= '0;
            out_line_q        <= '0;
            out_unit_q        <= '0;
            parity_q          <= '0;
        end else begin
            in_state_q        <= in_state_d;
            in_blocks_left_q  <= in_blocks_left_d;
            in_line_q         <= in_line_d;
            in_unit_q         <= in_unit_d;
            out_state_q       <= out_state_d;
            out_blocks_left_q <= out_blocks_left_d;
            out_line_q        <= out_line_d;
            out_unit_q        <= out_unit_d;
            parity_q          <= parity_d;
        end
    end

    // Outputs are forced low during the cycle reset is sampled, before state has cleared.
    assign dist_src_req_rdy  = rst ? 1'b0 : req_rdy_c;
    assign dist_src_data_rdy = rst ? 1'b0 : data_rdy_c;
    assign dist_unit_vals    = rst ? '0 : unit_vals_c;
    assign dist_unit_line    = rst ? '0 : src_dist_data;
    assign coll_unit_rdys    = rst ? '0 : coll_rdys_c;
    assign dist_dst_data_val = rst ? 1'b0 : dst_val_c;
    assign dist_dst_data     = rst ? '0 : dst_data_c;
    assign dist_dst_last     = rst ? 1'b0 : dst_last_c;
endmodule

// File: tb/tb_rs_encode_rr_dist_collect.sv
// Bench for rs_encode_rr_dist_collect: behavioural encoder units plus an in-order scoreboard,
// exercised on a 3-unit instance and a 1-unit instance.
module tb_rs_encode_rr_dist_collect;
    localparam int DW = 512;
    localparam int PW = 256;
    localparam int NL = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        logic          par;
    } exp_t;

    logic            clk, rst;
    logic            req_val, data_val, dst_rdy;
    logic [7:0]      req_nb;
    logic [DW-1:0]   data;
    logic [2:0]      u_rdys, u_vals;
    logic [3*DW-1:0] u_lines;
    logic [3*PW-1:0] u_pars;
    logic            sel;

    logic          a_req_rdy, a_data_rdy, a_dst_val, a_dst_last;
    logic [2:0]    a_unit_vals, a_coll_rdys;
    logic [DW-1:0] a_unit_line, a_dst_data;
    logic          b_req_rdy, b_data_rdy, b_dst_val, b_dst_last;
    logic [0:0]    b_unit_vals, b_coll_rdys;
    logic [DW-1:0] b_unit_line, b_dst_data;

    logic          c_req_rdy, c_data_rdy, c_dst_val, c_dst_last;
    logic [2:0]    c_unit_vals, c_coll_rdys;
    logic [DW-1:0] c_unit_line, c_dst_data;

    rs_encode_rr_dist_collect #(.DATA_W(DW), .PARITY_W(PW), .NUM_RS_UNITS(3), .NUM_LINES(NL),
                                .NUM_REQ_BLOCKS_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .src_dist_req_val(req_val & ~sel), .src_dist_req_num_blocks(req_nb), .dist_src_req_rdy(a_req_rdy),
        .src_dist_data_val(data_val & ~sel), .src_dist_data(data), .dist_src_data_rdy(a_data_rdy),
        .dist_unit_vals(a_unit_vals), .dist_unit_line(a_unit_line), .unit_dist_rdys(u_rdys),
        .unit_coll_vals(u_vals), .unit_coll_lines(u_lines), .unit_coll_paritys(u_pars),
        .coll_unit_rdys(a_coll_rdys),
        .dist_dst_data_val(a_dst_val), .dist_dst_data(a_dst_data), .dist_dst_last(a_dst_last),
        .dst_dist_data_rdy(dst_rdy)
    );

    rs_encode_rr_dist_collect #(.DATA_W(DW), .PARITY_W(PW), .NUM_RS_UNITS(1), .NUM_LINES(NL),
                                .NUM_REQ_BLOCKS_W(8)) dut_b (
        .clk(clk), .rst(rst),
        .src_dist_req_val(req_val & sel), .src_dist_req_num_blocks(req_nb), .dist_src_req_rdy(b_req_rdy),
        .src_dist_data_val(data_val & sel), .src_dist_data(data), .dist_src_data_rdy(b_data_rdy),
        .dist_unit_vals(b_unit_vals), .dist_unit_line(b_unit_line), .unit_dist_rdys(u_rdys[0:0]),
        .unit_coll_vals(u_vals[0:0]), .unit_coll_lines(u_lines[DW-1:0]), .unit_coll_paritys(u_pars[PW-1:0]),
        .coll_unit_rdys(b_coll_rdys),
        .dist_dst_data_val(b_dst_val), .dist_dst_data(b_dst_data), .dist_dst_last(b_dst_last),
        .dst_dist_data_rdy(dst_rdy)
    );

    always_comb begin
        c_req_rdy   = sel ? b_req_rdy   : a_req_rdy;
        c_data_rdy  = sel ? b_data_rdy  : a_data_rdy;
        c_unit_vals = sel ? {2'b00, b_unit_vals} : a_unit_vals;
        c_unit_line = sel ? b_unit_line : a_unit_line;
        c_coll_rdys = sel ? {2'b00, b_coll_rdys} : a_coll_rdys;
        c_dst_val   = sel ? b_dst_val   : a_dst_val;
        c_dst_data  = sel ? b_dst_data  : a_dst_data;
        c_dst_last  = sel ? b_dst_last  : a_dst_last;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Stimulus and scoreboard state
    logic [7:0]    req_q[$];
    logic [DW-1:0] src_q[$];
    exp_t          exp_q[$];
    int            last_at[$];
    logic [DW-1:0] ubuf [3][64];
    int            uhead [3];
    int            utail [3];
    int nu, ptr, req_id, cyc, beats, acc_cnt, acc_cyc, par_cyc;
    logic [2:0] rdy_mask;
    logic       dst_en;

    function automatic logic [DW-1:0] mk_line(input int u, input int r, input int b, input int l);
        logic [31:0] w;
        w = {8'(u), 8'(r), 8'(b), 8'(l)};
        return {16{w}};
    endfunction

    function automatic logic [PW-1:0] par_of(input logic [DW-1:0] d);
        return {8{~d[31:0]}};
    endfunction

    task automatic add_req(input int nb);
        exp_t e;
        logic [DW-1:0] d;
        req_q.push_back(8'(nb));
        for (int b = 0; b < nb; b++) begin
            d = '0;
            for (int l = 0; l < NL; l++) begin
                d = mk_line(ptr, req_id, b, l);
                src_q.push_back(d);
                e.d = d; e.last = 1'b0; e.par = 1'b0;
                exp_q.push_back(e);
            end
            e.d = {par_of(d), {(DW-PW){1'b0}}};
            e.last = (b == nb-1);
            e.par = 1'b1;
            exp_q.push_back(e);
            ptr = (ptr + 1) % nu;
        end
        req_id++;
    endtask

    // One cycle: present inputs at negedge, then record the handshakes the next posedge will take.
    task automatic step();
        int u;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (utail[k] > uhead[k]) begin
                u_vals[k] = 1'b1;
                u_lines[k*DW +: DW] = ubuf[k][uhead[k] % 64];
                u_pars[k*PW +: PW]  = par_of(ubuf[k][uhead[k] % 64]);
            end else begin
                u_vals[k] = 1'b0;
                u_lines[k*DW +: DW] = '0;
                u_pars[k*PW +: PW]  = '0;
            end
        end
        req_val  = (req_q.size() > 0);
        req_nb   = (req_q.size() > 0) ? req_q[0] : 8'd0;
        data_val = (src_q.size() > 0);
        data     = (src_q.size() > 0) ? src_q[0] : '0;
        u_rdys   = rdy_mask;
        dst_rdy  = dst_en;
        #1;
        cyc++;
        if (req_val && c_req_rdy) begin
            $display("cycle %0d: request accepted, %0d blocks", cyc, req_q[0]);
            void'(req_q.pop_front());
            acc_cnt++;
            acc_cyc = cyc;
        end
        if (data_val && c_data_rdy) begin
            u = int'(data[31:24]);
            check_eq("unit_sel", DW'(c_unit_vals), DW'(32'd1 << u));
            check_eq("unit_line", c_unit_line, data);
            ubuf[u][utail[u] % 64] = data;
            utail[u]++;
            void'(src_q.pop_front());
        end
        for (int k = 0; k < 3; k++) begin
            if (u_vals[k] && c_coll_rdys[k]) uhead[k]++;
        end
        if (c_dst_val && dst_rdy) begin
            beats++;
            if (exp_q.size() == 0) begin
                check_eq("extra_beat", DW'(1), DW'(0));
            end else begin
                check_eq("out_data", c_dst_data, exp_q[0].d);
                check_eq("out_last", DW'(c_dst_last), DW'(exp_q[0].last));
                if (exp_q[0].par) begin
                    $display("cycle %0d: block out, parity %h last=%0b", cyc, c_dst_data[DW-1 -: 32], c_dst_last);
                    if (par_cyc == 0) par_cyc = cyc;
                end
                void'(exp_q.pop_front());
            end
            if (c_dst_last) last_at.push_back(beats);
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || src_q.size() > 0 || req_q.size() > 0) && n < limit) begin
            step();
            n++;
        end
        check_eq("drain_done", DW'(exp_q.size() + src_q.size() + req_q.size()), DW'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_val = 1'b0;
        data_val = 1'b0;
        u_vals = '0;
        #1;
        check_eq("rst_req_rdy", DW'(c_req_rdy), DW'(0));
        check_eq("rst_data_rdy", DW'(c_data_rdy), DW'(0));
        check_eq("rst_unit_vals", DW'(c_unit_vals), DW'(0));
        check_eq("rst_unit_line", c_unit_line, DW'(0));
        check_eq("rst_coll_rdys", DW'(c_coll_rdys), DW'(0));
        check_eq("rst_dst_val", DW'(c_dst_val), DW'(0));
        check_eq("rst_dst_data", c_dst_data, DW'(0));
        check_eq("rst_dst_last", DW'(c_dst_last), DW'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_req_rdy", DW'(c_req_rdy), DW'(1));
        req_q.delete();
        src_q.delete();
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            uhead[k] = 0;
            utail[k] = 0;
        end
        ptr = 0;
    endtask

    initial begin
        int n;
        rst = 1'b1; sel = 1'b0; nu = 3; ptr = 0; req_id = 0; cyc = 0;
        req_val = 1'b0; req_nb = '0; data_val = 1'b0; data = '0;
        u_rdys = '0; u_vals = '0; u_lines = '0; u_pars = '0; dst_rdy = 1'b0;
        rdy_mask = 3'b111; dst_en = 1'b1;
        beats = 0; acc_cnt = 0; acc_cyc = 0; par_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            uhead[k] = 0;
            utail[k] = 0;
        end
        do_reset();

        // Single request of 3 blocks across units 0,1,2
        beats = 0;
        add_req(3);
        drain(200);
        check_eq("single_beats", DW'(beats), DW'(15));

        // Back-to-back requests: pointer carries over (2 blocks then 4 blocks starting at unit 2)
        beats = 0;
        last_at.delete();
        add_req(2);
        add_req(4);
        drain(400);
        check_eq("cont_beats", DW'(beats), DW'(30));
        check_eq("cont_last_cnt", DW'(last_at.size()), DW'(2));
        if (last_at.size() == 2) begin
            check_eq("cont_last0", DW'(last_at[0]), DW'(10));
            check_eq("cont_last1", DW'(last_at[1]), DW'(30));
        end

        // Meta queue full: output blocked, fourth request must wait for a pop
        dst_en = 1'b0; acc_cnt = 0; par_cyc = 0;
        for (int r = 0; r < 4; r++) add_req(1);
        repeat (30) step();
        check_eq("qfull_accepted", DW'(acc_cnt), DW'(3));
        check_eq("qfull_req_rdy", DW'(c_req_rdy), DW'(0));
        dst_en = 1'b1;
        drain(300);
        check_eq("qfull_all_acc", DW'(acc_cnt), DW'(4));
        check_eq("qfull_acc_cycle", DW'(acc_cyc), DW'(par_cyc + 2));

        // Reset while the first block's parity line is being presented
        add_req(2);
        n = 0;
        while (!(exp_q.size() > 0 && exp_q[0].par) && n < 100) begin
            step();
            n++;
        end
        check_eq("reach_parity", DW'(exp_q.size() > 0 && exp_q[0].par), DW'(1));
        do_reset();

        // Unit 1 stalls for 20 cycles; block on unit 0 still drains
        beats = 0;
        rdy_mask = 3'b101;
        add_req(3);
        repeat (20) step();
        check_eq("stall_beats", DW'(beats), DW'(5));
        check_eq("stall_src_left", DW'(src_q.size()), DW'(8));
        check_eq("stall_dst_val", DW'(c_dst_val), DW'(0));
        rdy_mask = 3'b111;
        drain(200);
        check_eq("stall_total", DW'(beats), DW'(15));

        // Single-unit instance: 5 blocks all on unit 0
        sel = 1'b1;
        nu = 1;
        do_reset();
        beats = 0;
        add_req(5);
        drain(300);
        check_eq("one_unit_beats", DW'(beats), DW'(25));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
